mult_op_scheduler: RTL and testbench
====================================

MULT_OP_SCHEDULER -- requirements
Module: mult_op_scheduler

Interface
REQ-001 SHALL have parameter width, default 8, operand width in bits.
REQ-002 SHALL have parameter depth, default 4, operand FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter timeout, default 32, maximum WAIT cycles before abort.
REQ-004 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port clear  input  1  synchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand pair offered.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a pair.
REQ-008 SHALL have port in_multiplier  input  width  two's-complement multiplier.
REQ-009 SHALL have port in_multiplicand  input  width  two's-complement multiplicand.
REQ-010 SHALL have port mul_load  output  1  one-cycle start pulse to the Booth multiplier.
REQ-011 SHALL have port mul_multiplier  output  width  operand driven to the multiplier.
REQ-012 SHALL have port mul_multiplicand  output  width  operand driven to the multiplier.
REQ-013 SHALL have port mul_done  input  1  multiplier completion flag.
REQ-014 SHALL have port mul_product  input  2*width  multiplier result.
REQ-015 SHALL have port out_valid  output  1  result held for consumer.
REQ-016 SHALL have port out_ready  input  1  consumer accepts result.
REQ-017 SHALL have port out_product  output  2*width  captured product.
REQ-018 SHALL have port out_err  output  1  result aborted by timeout.
REQ-019 SHALL have port busy  output  1  high whenever state != IDLE or FIFO non-empty.

Function
REQ-020 SHALL push a pair on an edge where in_valid && in_ready; in_ready = !full, independent of same-cycle pop.
REQ-021 SHALL implement FIFO with wrapping read/write pointers modulo depth and an occupancy count 0..depth.
REQ-022 SHALL run FSM states IDLE, LOAD, WAIT, HOLD.
REQ-023 IDLE -> LOAD on the edge where FIFO is non-empty; else remain.
REQ-024 In LOAD, mul_load SHALL be 1 for exactly one cycle with FIFO head on mul_multiplier/mul_multiplicand; head popped at end of cycle; -> WAIT.
REQ-025 mul_multiplier/mul_multiplicand SHALL stay registered and stable from LOAD through WAIT.
REQ-026 Pair accepted at edge E0 while IDLE and empty: mul_load SHALL be high between edges E1 and E2.
REQ-027 In WAIT, mul_done SHALL be ignored in the first WAIT cycle and qualified from the second WAIT cycle onward.
REQ-028 WAIT -> HOLD on qualified mul_done; mul_product captured into out_product, out_valid=1, out_err=0.
REQ-029 In HOLD, out_product/out_err SHALL remain stable while out_valid && !out_ready.
REQ-030 HOLD with out_ready: out_valid drops next edge; -> LOAD if FIFO non-empty, else IDLE.
REQ-031 Pushes SHALL continue during LOAD/WAIT/HOLD until FIFO full.
REQ-032 Product SHALL pass unmodified (full 2*width two's complement, no truncation).

Reset
REQ-033 clear SHALL have priority over all other inputs on the same edge.
REQ-034 After clear: state IDLE, FIFO empty, in_ready=1, mul_load=0, mul_multiplier=0, mul_multiplicand=0, out_valid=0, out_product=0, out_err=0, busy=0.
REQ-035 clear mid-operation (any state) SHALL discard in-flight and queued pairs; no result SHALL be emitted for them.

Configuration
REQ-036 Macro MULT_TIMEOUT_EN SHALL enable the WAIT watchdog.
REQ-037 With MULT_TIMEOUT_EN: counter cleared on LOAD; if no qualified mul_done after timeout WAIT cycles -> HOLD with out_product=0, out_err=1, out_valid=1.
REQ-038 Without MULT_TIMEOUT_EN: no counter; WAIT holds indefinitely; out_err tied 0.

Verification
REQ-039 Push (5,3), model multiplier done after 10 cycles, out_ready=1 -> out_product=16'd15, out_err=0, one mul_load pulse.
REQ-040 Push (-7,4) then (-6,-2) back-to-back -> results 16'hFFE4 then 16'd12, in order, two mul_load pulses.
REQ-041 out_ready=0, push 6 pairs continuously -> pair 1 reaches HOLD, pairs 2-5 fill FIFO, in_ready=0 for pair 6 until out_ready=1.
REQ-042 mul_done held 1 from previous op, push (9,-5) -> stale done ignored in first WAIT cycle; result 16'hFFD3 captured on a later qualified done.
REQ-043 Assert clear in WAIT with 3 pairs queued -> next cycle all outputs at reset values, no out_valid pulse follows.
REQ-044 With MULT_TIMEOUT_EN, mul_done held 0 -> out_valid=1, out_err=1, out_product=0 after 32 WAIT cycles; next pair processes normally.

Source files
------------

// File: rtl/mult_op_scheduler.sv
// Operand-pair FIFO feeding a multi-cycle Booth multiplier, with a held result stage.
// Define MULT_TIMEOUT_EN to add the WAIT watchdog that aborts with out_err after `timeout` cycles.
module mult_op_scheduler #(
    parameter int width   = 8,
    parameter int depth   = 4,
    parameter int timeout = 32
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [width-1:0]    in_multiplier,
    input  logic signed [width-1:0]    in_multiplicand,
    output logic                       mul_load,
    output logic signed [width-1:0]    mul_multiplier,
    output logic signed [width-1:0]    mul_multiplicand,
    input  logic                       mul_done,
    input  logic signed [2*width-1:0]  mul_product,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [2*width-1:0]  out_product,
    output logic                       out_err,
    output logic                       busy
);
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_t;

    state_t state_q, state_d;

    logic signed [width-1:0]   fifo_mplr_q [depth];
    logic signed [width-1:0]   fifo_mcnd_q [depth];
    logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             count_q;
    logic                      push, pop;

    logic signed [width-1:0]   mplr_q, mplr_d;
    logic signed [width-1:0]   mcnd_q, mcnd_d;
    logic signed [2*width-1:0] prod_q, prod_d;
    logic                      out_valid_q, out_valid_d;
    logic                      first_q, first_d;

`ifdef MULT_TIMEOUT_EN
    localparam int TW = $clog2(timeout + 1);
    logic [TW-1:0]             tmo_q, tmo_d;
    logic                      err_q, err_d;
`else
    // The watchdog limit has no effect unless the watchdog is built in.
    if (timeout < 1) begin : g_timeout_unused
    end
`endif

    assign in_ready         = (count_q != CW'(depth));
    assign push             = in_valid && in_ready;
    assign pop              = (state_q == LOAD);
    assign mul_load         = (state_q == LOAD);
    assign mul_multiplier   = mplr_q;
    assign mul_multiplicand = mcnd_q;
    assign out_valid        = out_valid_q;
    assign out_product      = prod_q;
    assign busy             = (state_q != IDLE) || (count_q != '0);

`ifdef MULT_TIMEOUT_EN
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    // Storage is not reset; only pointers and occupancy define validity.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            fifo_mplr_q[wr_ptr_q] <= in_multiplier;
            fifo_mcnd_q[wr_ptr_q] <= in_multiplicand;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= IDLE;
            mplr_q      <= '0;
            mcnd_q      <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            first_q     <= 1'b0;
`ifdef MULT_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mplr_q      <= mplr_d;
            mcnd_q      <= mcnd_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
            first_q     <= first_d;
`ifdef MULT_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    // Operands are latched on entry to LOAD so they stay put for the whole multiply.
    always_comb begin
        state_d     = state_q;
        mplr_d      = mplr_q;
        mcnd_d      = mcnd_q;
        prod_d      = prod_q;
        out_valid_d = out_valid_q;
        first_d     = first_q;
`ifdef MULT_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = LOAD;
                    mplr_d  = fifo_mplr_q[rd_ptr_q];
                    mcnd_d  = fifo_mcnd_q[rd_ptr_q];
                end
            end
            LOAD: begin
                state_d = WAIT;
                first_d = 1'b1;
`ifdef MULT_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            WAIT: begin
                first_d = 1'b0;
                // A done left over from the previous operation can only show in the first cycle.
                if (mul_done && !first_q) begin
                    state_d     = HOLD;
                    prod_d      = mul_product;
                    out_valid_d = 1'b1;
`ifdef MULT_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end
`ifdef MULT_TIMEOUT_EN
                else if (tmo_q == TW'(timeout - 1)) begin
                    state_d     = HOLD;
                    prod_d      = '0;
                    out_valid_d = 1'b1;
                    err_d       = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (count_q != '0) begin
                        state_d = LOAD;
                        mplr_d  = fifo_mplr_q[rd_ptr_q];
                        mcnd_d  = fifo_mcnd_q[rd_ptr_q];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_op_scheduler.sv
// Self-checking bench for mult_op_scheduler: directed vector table, corner sequences, random traffic.
module tb_mult_op_scheduler;
    localparam int W = 8;
    localparam int D = 4;
    localparam int T = 32;

    logic                    clock = 1'b0;
    logic                    clear;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     in_multiplier, in_multiplicand;
    logic                    mul_load;
    logic signed [W-1:0]     mul_multiplier, mul_multiplicand;
    logic                    mul_done;
    logic signed [2*W-1:0]   mul_product;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [2*W-1:0]   out_product;
    logic                    out_err;
    logic                    busy;

    int checks = 0;
    int failures = 0;
    int loads = 0;

    mult_op_scheduler #(.width(W), .depth(D), .timeout(T)) dut (
        .clock(clock), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_multiplier(in_multiplier), .in_multiplicand(in_multiplicand),
        .mul_load(mul_load), .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
        .mul_done(mul_done), .mul_product(mul_product),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_err(out_err), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: per-pair latency for the multiplier model, and expected results in order.
    typedef struct { int lat; bit stale; } job_t;
    job_t                  jobq[$];
    logic signed [2*W-1:0] expq[$];
    logic                  errq[$];
    int                    nxt_lat = 3;
    bit                    nxt_stale = 1'b0;

    job_t                  job;
    int                    m_cnt = 0, m_keep = 0;
    logic signed [2*W-1:0] m_prod, ea, eb, ma, mb, ep;
    logic                  ee;
    logic                  hold_prev = 1'b0, prev_err;
    logic signed [2*W-1:0] prev_prod;

    always @(negedge clock) begin
        if (clear) begin
            jobq.delete(); expq.delete(); errq.delete();
            m_cnt = 0; m_keep = 0;
            mul_done = 1'b0; mul_product = '0;
            hold_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                ea = in_multiplier;
                eb = in_multiplicand;
                jobq.push_back('{lat: nxt_lat, stale: nxt_stale});
`ifdef MULT_TIMEOUT_EN
                if (nxt_lat == 0) begin expq.push_back('0); errq.push_back(1'b1); end else
`endif
                begin expq.push_back(ea * eb); errq.push_back(1'b0); end
            end
            // Behavioural multiplier: result after lat cycles, done then held until the next load.
            if (mul_load) begin
                loads++;
                checks++;
                if (jobq.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_load: got mul_load with operands %0d,%0d, expected no load", mul_multiplier, mul_multiplicand);
                    m_cnt = 0;
                end else begin
                    job = jobq.pop_front();
                    ma = mul_multiplier;
                    mb = mul_multiplicand;
                    m_prod = ma * mb;
                    m_cnt = job.lat;
                    m_keep = job.stale ? 1 : 0;
                    if (!job.stale) mul_done = 1'b0;
                end
            end else if (m_cnt > 0) begin
                if (m_keep > 0) m_keep--;
                else mul_done = 1'b0;
                m_cnt--;
                if (m_cnt == 0) begin
                    mul_done = 1'b1;
                    mul_product = m_prod;
                end
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_result: got product %0h, expected no result", out_product);
                end else begin
                    ep = expq.pop_front();
                    ee = errq.pop_front();
                    check("sb_product", out_product, ep);
                    check("sb_err", {15'd0, out_err}, {15'd0, ee});
                end
            end
            if (hold_prev) begin
                check("hold_valid", {15'd0, out_valid}, 16'd1);
                check("hold_product", out_product, prev_prod);
                check("hold_err", {15'd0, out_err}, {15'd0, prev_err});
            end
            hold_prev = out_valid && !out_ready;
            prev_prod = out_product;
            prev_err  = out_err;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                        input int lat, input bit stale);
        int n;
        n = 0;
        in_multiplier = a;
        in_multiplicand = b;
        nxt_lat = lat;
        nxt_stale = stale;
        in_valid = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_stall: in_ready=0 for %0d cycles, expected acceptance", n);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!out_valid && n < limit);
        check(name, {15'd0, out_valid}, 16'd1);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy && n < limit);
        check(name, {15'd0, busy}, 16'd0);
        check({name, "_queue"}, 16'(expq.size()), 16'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
        check({tag, "_mul_load"}, {15'd0, mul_load}, 16'd0);
        check({tag, "_mplr"}, mul_multiplier, 16'd0);
        check({tag, "_mcnd"}, mul_multiplicand, 16'd0);
        check({tag, "_out_valid"}, {15'd0, out_valid}, 16'd0);
        check({tag, "_out_product"}, out_product, 16'd0);
        check({tag, "_out_err"}, {15'd0, out_err}, 16'd0);
        check({tag, "_busy"}, {15'd0, busy}, 16'd0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clock);
    endtask

    typedef struct {
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        int                  lat;
        bit                  stale;
        logic [2*W-1:0]      exp;
    } vec_t;

    localparam int NV = 8;
    vec_t vt[NV];
    int   l0, n, sent, cyc;
    bit   acc;

    initial begin
        vt[0] = '{a: 5,    b: 3,    lat: 10, stale: 1'b0, exp: 16'd15};
        vt[1] = '{a: -7,   b: 4,    lat: 3,  stale: 1'b0, exp: 16'hFFE4};
        vt[2] = '{a: -6,   b: -2,   lat: 5,  stale: 1'b0, exp: 16'd12};
        vt[3] = '{a: 9,    b: -5,   lat: 6,  stale: 1'b1, exp: 16'hFFD3};
        vt[4] = '{a: -128, b: -128, lat: 2,  stale: 1'b0, exp: 16'h4000};
        vt[5] = '{a: 127,  b: -128, lat: 7,  stale: 1'b0, exp: 16'hC080};
        vt[6] = '{a: 0,    b: -1,   lat: 1,  stale: 1'b1, exp: 16'h0000};
        vt[7] = '{a: -1,   b: -1,   lat: 4,  stale: 1'b1, exp: 16'h0001};

        clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_multiplier = '0; in_multiplicand = '0;
        mul_done = 1'b0; mul_product = '0;
        tick(); tick();
        clear = 1'b0;
        @(negedge clock);
        check_reset("reset");

        // Single pairs from idle: load timing, operand stability, product and one pulse each.
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < NV; i++) begin
            l0 = loads;
            push(vt[i].a, vt[i].b, vt[i].lat, vt[i].stale);
            @(negedge clock);
            check("pre_load", {15'd0, mul_load}, 16'd0);
            @(negedge clock);
            check("load_pulse", {15'd0, mul_load}, 16'd1);
            check("load_mplr", mul_multiplier, vt[i].a);
            check("load_mcnd", mul_multiplicand, vt[i].b);
            @(negedge clock);
            check("load_once", {15'd0, mul_load}, 16'd0);
            check("wait_mplr", mul_multiplier, vt[i].a);
            check("wait_mcnd", mul_multiplicand, vt[i].b);
            wait_valid("vec_valid", 100);
            check("vec_product", out_product, vt[i].exp);
            check("vec_err", {15'd0, out_err}, 16'd0);
            tick();
            check("vec_loads", 16'(loads - l0), 16'd1);
        end

        // Back-to-back pair: in-order results, two pulses.
        l0 = loads;
        push(-7, 4, 4, 1'b0);
        push(-6, -2, 2, 1'b0);
        wait_valid("b2b_valid0", 100);
        check("b2b_product0", out_product, 16'hFFE4);
        wait_valid("b2b_valid1", 100);
        check("b2b_product1", out_product, 16'd12);
        tick();
        check("b2b_loads", 16'(loads - l0), 16'd2);

        // Backpressure: one result held, four queued, sixth pair refused until drained.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(W'(i), W'(-i), 3, 1'b0);
        in_multiplier = 8'sd6; in_multiplicand = -8'sd6; nxt_lat = 3; nxt_stale = 1'b0;
        in_valid = 1'b1;
        repeat (20) @(negedge clock);
        check("full_in_ready", {15'd0, in_ready}, 16'd0);
        check("full_out_valid", {15'd0, out_valid}, 16'd1);
        check("full_product", out_product, 16'hFFFF);
        check("full_busy", {15'd0, busy}, 16'd1);
        tick();
        out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!in_ready && n < 50);
        check("refill_in_ready", {15'd0, in_ready}, 16'd1);
        tick();
        in_valid = 1'b0;
        wait_idle("full_drain", 300);

        // Clear during WAIT with three pairs queued: nothing may come out afterwards.
        push(11, 12, 20, 1'b0);
        push(1, 2, 3, 1'b0);
        push(3, 4, 3, 1'b0);
        push(5, 6, 3, 1'b0);
        pulse_clear();
        check_reset("midclear");
        n = 0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid || mul_load) n++;
        end
        check("midclear_silent", 16'(n), 16'd0);

        // Multiplier that never finishes.
        push(3, 4, 0, 1'b0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!mul_load && n < 20);
        check("tmo_load", {15'd0, mul_load}, 16'd1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!out_valid && n < 100);
`ifdef MULT_TIMEOUT_EN
        check("tmo_cycles", 16'(n), 16'd33);
        check("tmo_err", {15'd0, out_err}, 16'd1);
        check("tmo_product", out_product, 16'd0);
        tick();
        push(2, -3, 4, 1'b0);
        wait_valid("post_tmo_valid", 100);
        check("post_tmo_product", out_product, 16'hFFFA);
        check("post_tmo_err", {15'd0, out_err}, 16'd0);
        tick();
`else
        check("no_tmo_valid", {15'd0, out_valid}, 16'd0);
        check("no_tmo_busy", {15'd0, busy}, 16'd1);
        pulse_clear();
        check_reset("no_tmo_clear");
`endif

        // Random traffic against the scoreboard.
        sent = 0;
        cyc = 0;
        while ((sent < 40 || busy) && cyc < 6000) begin
            in_valid = (sent < 40) && ($urandom_range(0, 2) != 0);
            in_multiplier = W'($urandom);
            in_multiplicand = W'($urandom);
            nxt_lat = $urandom_range(1, 12);
            nxt_stale = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("rand_sent", 16'(sent), 16'd40);
        wait_idle("rand_drain", 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
